ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Configuration-chain controller that serially loads a bitstream into a chain of configuration flops threaded head-to-tail through IO tiles (ccff_head into the first tile, ccff_tail out of the last).
- Accepts bytes on a valid/ready stream and gates chain shifting.
- Verifies chain continuity with a leading sentinel that must re-emerge at ccff_tail.
- Releases IO isolation (isol_n) only after a verified load.

Parameters:
- CHAIN_LEN, 20, number of config flops in the chain; must be >= SENT_W.
- DATA_W, 8, bitstream word width.
- SENT_W, 8, sentinel length in bits.
- SENTINEL, 8'hA5, sentinel pattern, shifted MSB first.

Ports:
- prog_clk  in  1  programming clock; all state is on the rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE and ERROR.
- bs_valid  in  1  bitstream word valid.
- bs_data  in  DATA_W  bitstream word; MSB shifted first.
- bs_ready  out  1  word accepted when bs_valid && bs_ready.
- ccff_head  out  1  serial data into the chain.
- chain_shift_en  out  1  registered; the chain captures ccff_head on each prog_clk edge where this is 1.
- ccff_tail  in  1  serial data out of the chain.
- isol_n  out  1  0 = IOs isolated; 1 only in DONE.
- busy  out  1  high in SENT, LOAD and CHECK.
- done  out  1  level, high in DONE.
- error  out  1  level, high in ERROR.

Behaviour:
- Reset values: state IDLE, all outputs 0 (isol_n=0, bs_ready=0, chain_shift_en=0, ccff_head=0); all counters 0.
- Reset mid-operation aborts to IDLE the same edge. Chain contents are then undefined and isol_n stays 0.
- Shift count k counts completed shifts, 1..TOTAL, where TOTAL = SENT_W + CHAIN_LEN. Width is clog2(TOTAL+1).

State machine:
- IDLE: start -> SENT; clears k, loads SENTINEL into the serializer.
- SENT: chain_shift_en=1 every cycle; ccff_head = serializer MSB. After SENT_W shifts -> LOAD. No stall is possible.
- LOAD:
  - bs_ready=1 only when the serializer is empty; an accepted word loads the serializer.
  - chain_shift_en=1 only while the serializer holds a bit. An empty serializer with bs_valid=0 is a stall: chain_shift_en=0, k holds.
  - Exactly CHAIN_LEN bits are shifted. Once k reaches TOTAL, leftover low bits of the final word are discarded, bs_ready=0, and the state moves to CHECK.
  - Words offered after the last needed word are not accepted.
- CHECK: one cycle; evaluates the compare flag -> DONE if clean, else ERROR. chain_shift_en=0.
- DONE: isol_n=1, done=1. start -> SENT, and isol_n falls to 0 on that edge.
- ERROR: isol_n=0, error=1. start -> SENT, and error clears.
- start while busy is ignored.

Continuity check:
- Sentinel bit i (1-based, MSB first) must appear on ccff_tail after shift k = CHAIN_LEN + i - 1, for i = 1..SENT_W.
- ccff_tail is sampled in the cycle after each qualifying shift edge, using a one-cycle-delayed copy of chain_shift_en and k.
- Any mismatch sets a sticky mismatch flag, cleared on start.
- The final sample (k = TOTAL-1) is taken during LOAD, before the last shift completes, so CHECK needs no extra wait.

Simultaneous events: start and pReset together -> reset wins.

Decomposition:
- Package ccff_loader_pkg: state enum (IDLE, SENT, LOAD, CHECK, DONE, ERROR), SENTINEL default, counter-width function.
- Sub-module ccff_piso: DATA_W parallel-in serial-out shifter with load, shift, empty and msb outputs. It is shared by the SENT and LOAD phases.

Test Plan:
- Nominal load:
  - Setup: CHAIN_LEN=20, behavioural 20-flop chain model, bytes 8'h12, 8'h34, 8'h5F streamed back-to-back.
  - Response: exactly 28 chain_shift_en pulses; chain holds 0001_0010_0011_0100_0101 (first bit deepest); 8'h5F low nibble discarded.
  - Response: done=1, isol_n=1 one cycle after the last shift; third byte accepted once, no fourth accepted.
- Stalled stream:
  - Stimulus: same data, bs_valid deasserted 5 cycles between bytes.
  - Response: chain_shift_en low during stalls; k frozen; identical final chain contents and done.
- Broken chain:
  - Stimulus: chain model with ccff_tail stuck at 0.
  - Response: error=1, isol_n=0, done=0.
  - Response: length-19 model also gives error=1, since the sentinel emerges misaligned.
- Restart from DONE:
  - Stimulus: pulse start in DONE.
  - Response: isol_n drops the same edge, busy=1, second load with bytes 8'hFF x3 yields an all-ones chain, then done.
- Reset mid-load:
  - Stimulus: assert pReset after 12 shifts.
  - Response: next cycle all outputs 0, state IDLE; a subsequent full load completes with done=1.
- start while busy:
  - Stimulus: pulse start during LOAD.
  - Response: ignored; shift count and final result unchanged.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SENT  = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [7:0] SENTINEL_DEF = 8'hA5;

    function automatic int cnt_width(input int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in serial-out shifter, MSB first; clear beats load beats shift.
module ccff_piso
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_msb,
    output logic              o_empty,
    output logic              o_last
);

    localparam int CW = cnt_width(DATA_W);

    logic [DATA_W-1:0] r_data;
    logic [CW-1:0]     r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cnt  <= CW'(DATA_W);
        end else if (i_shift && (r_cnt != '0)) begin
            r_data <= r_data << 1;
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    assign o_msb   = r_data[DATA_W-1];
    assign o_empty = (r_cnt == '0);
    assign o_last  = (r_cnt == CW'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Serially loads a sentinel plus bitstream into a configuration-flop chain,
// checks the sentinel re-emerges at the tail, and only then releases isolation.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int                CHAIN_LEN = 20,
    parameter int                DATA_W    = 8,
    parameter int                SENT_W    = 8,
    parameter logic [SENT_W-1:0] SENTINEL  = SENT_W'(SENTINEL_DEF)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              bs_valid,
    input  logic [DATA_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              chain_shift_en,
    input  logic              ccff_tail,
    output logic              isol_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int                TOTAL     = SENT_W + CHAIN_LEN;
    localparam int                KW        = cnt_width(TOTAL);
    localparam logic [KW-1:0]     K_SENT    = KW'(SENT_W);
    localparam logic [KW-1:0]     K_CHAIN   = KW'(CHAIN_LEN);
    localparam logic [KW-1:0]     K_TOTAL   = KW'(TOTAL);
    localparam logic [DATA_W-1:0] SENT_WORD = DATA_W'(SENTINEL) << (DATA_W - SENT_W);

    state_t              r_state;
    state_t              w_next;
    logic [KW-1:0]       r_k;
    logic [KW-1:0]       w_k_next;
    logic                r_shift_en;
    logic                r_shift_en_d;
    logic                r_mismatch;
    logic [SENT_W-1:0]   r_exp;
    logic                w_start_ok;
    logic                w_en_next;
    logic                w_piso_load;
    logic                w_piso_clr;
    logic [DATA_W-1:0]   w_piso_data;
    logic                w_msb;
    logic                w_empty;
    logic                w_last;
    logic                w_sample;

    ccff_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .i_clk   (prog_clk),
        .i_rst   (pReset),
        .i_clr   (w_piso_clr),
        .i_load  (w_piso_load),
        .i_shift (r_shift_en),
        .i_data  (w_piso_data),
        .o_msb   (w_msb),
        .o_empty (w_empty),
        .o_last  (w_last)
    );

    // k advances on every edge where the chain actually captures a bit.
    assign w_k_next = r_k + KW'(r_shift_en);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR: if (start) w_next = SENT;
            SENT:              if (w_k_next == K_SENT) w_next = LOAD;
            LOAD:              if (w_k_next == K_TOTAL) w_next = CHECK;
            CHECK:             w_next = r_mismatch ? ERROR : DONE;
            default:           w_next = IDLE;
        endcase
    end

    // Enable is registered, so it is computed from what the serializer will hold next cycle.
    always_comb begin
        bs_ready    = 1'b0;
        isol_n      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        w_start_ok  = 1'b0;
        w_en_next   = 1'b0;
        w_piso_load = 1'b0;
        w_piso_clr  = 1'b0;
        w_piso_data = bs_data;
        case (r_state)
            IDLE, DONE, ERROR: begin
                isol_n = (r_state == DONE);
                done   = (r_state == DONE);
                error  = (r_state == ERROR);
                if (start) begin
                    w_start_ok  = 1'b1;
                    w_piso_load = 1'b1;
                    w_piso_data = SENT_WORD;
                    w_en_next   = 1'b1;
                end
            end
            SENT: begin
                busy       = 1'b1;
                w_en_next  = (w_k_next != K_SENT);
                w_piso_clr = !w_en_next;
            end
            LOAD: begin
                busy        = 1'b1;
                bs_ready    = w_empty;
                w_piso_load = bs_valid && w_empty;
                if (w_k_next == K_TOTAL) begin
                    w_piso_clr = 1'b1;
                end else begin
                    w_en_next = w_piso_load || (r_shift_en ? !w_last : !w_empty);
                end
            end
            CHECK: busy = 1'b1;
            default: ;
        endcase
    end

    // Tail is sampled the cycle after shifts CHAIN_LEN .. TOTAL-1 complete.
    assign w_sample = r_shift_en_d && (r_k >= K_CHAIN) && (r_k < K_TOTAL);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_k          <= '0;
            r_shift_en   <= 1'b0;
            r_shift_en_d <= 1'b0;
            r_mismatch   <= 1'b0;
            r_exp        <= '0;
        end else begin
            r_shift_en   <= w_en_next;
            r_shift_en_d <= r_shift_en;
            if (w_start_ok) begin
                r_k        <= '0;
                r_mismatch <= 1'b0;
                r_exp      <= SENTINEL;
            end else begin
                r_k <= w_k_next;
                if (w_sample) begin
                    if (ccff_tail != r_exp[SENT_W-1]) r_mismatch <= 1'b1;
                    r_exp <= r_exp << 1;
                end
            end
        end
    end

    assign ccff_head      = w_msb;
    assign chain_shift_en = r_shift_en;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural flop chain plus stream-level reference model.
module tb_ccff_chain_loader;

    localparam int         CHAIN_LEN = 20;
    localparam int         DATA_W    = 8;
    localparam int         SENT_W    = 8;
    localparam int         TOTAL     = SENT_W + CHAIN_LEN;
    localparam logic [7:0] SENTINEL  = 8'hA5;

    logic        clk = 1'b0;
    logic        pReset;
    logic        start;
    logic        bs_valid;
    logic [7:0]  bs_data;
    logic        bs_ready;
    logic        ccff_head;
    logic        chain_shift_en;
    logic        ccff_tail;
    logic        isol_n;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Behavioural chain: chain_m[0] is next to the head, chain_m[len-1] drives the tail.
    logic [63:0] chain_m = '0;
    int          chain_len_m = CHAIN_LEN;
    bit          stuck0 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) if (chain_shift_en) chain_m <= {chain_m[62:0], ccff_head};
    always_comb ccff_tail = stuck0 ? 1'b0 : chain_m[chain_len_m-1];

    ccff_chain_loader dut (
        .prog_clk       (clk),
        .pReset         (pReset),
        .start          (start),
        .bs_valid       (bs_valid),
        .bs_data        (bs_data),
        .bs_ready       (bs_ready),
        .ccff_head      (ccff_head),
        .chain_shift_en (chain_shift_en),
        .ccff_tail      (ccff_tail),
        .isol_n         (isol_n),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    // Stimulus settings and results of one load.
    logic [7:0] words [0:7];
    int  n_words, gap, poke_at, abort_at;
    bit  rnd_gap;
    int  res_shifts, res_acc, res_last_en, res_end, res_stall_bad;
    bit  res_timeout, res_aborted, res_poked;
    logic res_busy_st, res_isol_st, res_err_st;

    bit stream_q[$];

    function automatic void build_stream(input int nw);
        stream_q.delete();
        for (int i = SENT_W - 1; i >= 0; i--) stream_q.push_back(SENTINEL[i]);
        for (int w = 0; w < nw; w++)
            for (int b = 7; b >= 0; b--) stream_q.push_back(words[w][b]);
    endfunction

    // After TOTAL shifts the flop at depth p holds stream bit TOTAL-p.
    function automatic logic [19:0] ref_chain(input int nw);
        logic [19:0] v;
        build_stream(nw);
        for (int p = 1; p <= CHAIN_LEN; p++) v[p-1] = stream_q[TOTAL-p];
        return v;
    endfunction

    // A chain of length len shows stream bit k-len at its tail after k shifts.
    function automatic bit ref_err(input int len, input bit stuck, input int nw);
        bit e = 1'b0;
        bit t;
        build_stream(nw);
        for (int i = 1; i <= SENT_W; i++) begin
            t = stuck ? 1'b0 : stream_q[CHAIN_LEN + i - 1 - len];
            if (t != SENTINEL[SENT_W-i]) e = 1'b1;
        end
        return e;
    endfunction

    task automatic run_load();
        int cyc = 0;
        int idx = 0;
        int wait_cnt = 0;
        res_shifts = 0; res_acc = 0; res_last_en = -1; res_stall_bad = 0;
        res_timeout = 0; res_aborted = 0; res_poked = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        res_busy_st = busy; res_isol_st = isol_n; res_err_st = error;
        while (1) begin
            if (done === 1'b1 || error === 1'b1) break;
            if (cyc >= 3000) begin res_timeout = 1; break; end
            start = 1'b0;
            if (idx < n_words && wait_cnt == 0) begin
                bs_valid = 1'b1;
                bs_data  = words[idx];
            end else begin
                bs_valid = 1'b0;
                if (wait_cnt > 0) wait_cnt--;
            end
            if (bs_valid && bs_ready) begin
                idx++; res_acc++;
                wait_cnt = rnd_gap ? $urandom_range(0, gap) : gap;
            end
            if (chain_shift_en) begin res_shifts++; res_last_en = cyc; end
            if (bs_ready && !bs_valid && chain_shift_en) res_stall_bad++;
            if (poke_at >= 0 && !res_poked && res_shifts == poke_at) begin
                start = 1'b1; res_poked = 1;
            end
            if (abort_at >= 0 && res_shifts == abort_at) begin
                pReset = 1'b1; res_aborted = 1; break;
            end
            @(negedge clk);
            cyc++;
        end
        res_end  = cyc;
        bs_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic set_defaults();
        gap = 0; rnd_gap = 0; poke_at = -1; abort_at = -1;
        chain_len_m = CHAIN_LEN; stuck0 = 0;
    endtask

    task automatic test_reset();
        pReset = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({isol_n, bs_ready, chain_shift_en, ccff_head, busy, done, error} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {isol_n, bs_ready, chain_shift_en, ccff_head, busy, done, error});
        end
        pReset = 1'b0;
        @(negedge clk);
        checks++;
        if ({isol_n, busy, done, error} !== 4'b0) begin
            errors++;
            $display("FAIL idle_outputs: got %b expected 0000", {isol_n, busy, done, error});
        end
    endtask

    task automatic test_nominal();
        set_defaults();
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h5F; words[3] = 8'hC3;
        n_words = 4;
        run_load();
        checks++;
        if (res_timeout !== 1'b0) begin errors++; $display("FAIL nominal_timeout: load never finished"); end
        checks++;
        if (res_shifts != TOTAL) begin errors++; $display("FAIL nominal_shifts: got %0d expected %0d", res_shifts, TOTAL); end
        checks++;
        if (res_acc != 3) begin errors++; $display("FAIL nominal_accepted: got %0d expected 3", res_acc); end
        checks++;
        if (chain_m[19:0] !== 20'h12345) begin errors++; $display("FAIL nominal_chain: got %h expected 12345", chain_m[19:0]); end
        checks++;
        if (chain_m[19:0] !== ref_chain(3)) begin errors++; $display("FAIL nominal_chain_ref: got %h expected %h", chain_m[19:0], ref_chain(3)); end
        checks++;
        if ({done, isol_n, error} !== 3'b110) begin errors++; $display("FAIL nominal_status: got done/isol/err %b expected 110", {done, isol_n, error}); end
        checks++;
        if (res_end - res_last_en != 2) begin errors++; $display("FAIL nominal_done_latency: got %0d expected 2", res_end - res_last_en); end
    endtask

    task automatic test_restart_from_done();
        set_defaults();
        for (int i = 0; i < 4; i++) words[i] = 8'hFF;
        n_words = 3;
        run_load();
        checks++;
        if ({res_busy_st, res_isol_st} !== 2'b10) begin errors++; $display("FAIL restart_edge: got busy/isol %b expected 10", {res_busy_st, res_isol_st}); end
        checks++;
        if (chain_m[19:0] !== 20'hFFFFF) begin errors++; $display("FAIL restart_chain: got %h expected fffff", chain_m[19:0]); end
        checks++;
        if ({done, isol_n, res_shifts == TOTAL} !== 3'b111) begin errors++; $display("FAIL restart_done: got done/isol/shifts_ok %b expected 111", {done, isol_n, res_shifts == TOTAL}); end
    endtask

    task automatic test_stall();
        set_defaults();
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h5F;
        n_words = 3; gap = 5;
        run_load();
        checks++;
        if (res_stall_bad != 0) begin errors++; $display("FAIL stall_shift_en: got %0d shifting stall cycles expected 0", res_stall_bad); end
        checks++;
        if (res_shifts != TOTAL) begin errors++; $display("FAIL stall_shifts: got %0d expected %0d", res_shifts, TOTAL); end
        checks++;
        if (chain_m[19:0] !== ref_chain(3)) begin errors++; $display("FAIL stall_chain: got %h expected %h", chain_m[19:0], ref_chain(3)); end
        checks++;
        if ({done, error} !== 2'b10) begin errors++; $display("FAIL stall_done: got done/err %b expected 10", {done, error}); end
    endtask

    task automatic test_broken_chain();
        bit exp_err;
        set_defaults();
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h5F;
        n_words = 3; stuck0 = 1;
        exp_err = ref_err(CHAIN_LEN, 1'b1, 3);
        run_load();
        checks++;
        if ({error, done, isol_n} !== {exp_err, !exp_err, !exp_err}) begin
            errors++; $display("FAIL stuck_status: got err/done/isol %b expected %b", {error, done, isol_n}, {exp_err, !exp_err, !exp_err});
        end
        stuck0 = 0; chain_len_m = CHAIN_LEN - 1;
        exp_err = ref_err(CHAIN_LEN - 1, 1'b0, 3);
        run_load();
        checks++;
        if ({res_err_st, res_busy_st} !== 2'b01) begin errors++; $display("FAIL error_restart: got err/busy %b expected 01", {res_err_st, res_busy_st}); end
        checks++;
        if ({error, done, isol_n} !== {exp_err, !exp_err, !exp_err}) begin
            errors++; $display("FAIL short_chain_status: got err/done/isol %b expected %b", {error, done, isol_n}, {exp_err, !exp_err, !exp_err});
        end
        chain_len_m = CHAIN_LEN;
    endtask

    task automatic test_random();
        bit exp_err;
        for (int it = 0; it < 5; it++) begin
            set_defaults();
            for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
            n_words = 3 + $urandom_range(0, 2);
            gap = 6; rnd_gap = 1;
            exp_err = ref_err(CHAIN_LEN, 1'b0, 3);
            run_load();
            checks++;
            if (res_shifts != TOTAL || res_acc != 3) begin
                errors++; $display("FAIL random_counts[%0d]: got shifts %0d acc %0d expected %0d 3", it, res_shifts, res_acc, TOTAL);
            end
            checks++;
            if (chain_m[19:0] !== ref_chain(3)) begin errors++; $display("FAIL random_chain[%0d]: got %h expected %h", it, chain_m[19:0], ref_chain(3)); end
            checks++;
            if ({error, done} !== {exp_err, !exp_err}) begin errors++; $display("FAIL random_status[%0d]: got err/done %b expected %b", it, {error, done}, {exp_err, !exp_err}); end
        end
    endtask

    task automatic test_reset_mid_load();
        set_defaults();
        words[0] = 8'h9C; words[1] = 8'h3E; words[2] = 8'h71;
        n_words = 3; abort_at = 12;
        run_load();
        @(negedge clk);
        checks++;
        if (!res_aborted || {isol_n, bs_ready, chain_shift_en, ccff_head, busy, done, error} !== 7'b0) begin
            errors++; $display("FAIL midreset_outputs: got aborted=%0d outputs %b expected 1 0000000", res_aborted,
                               {isol_n, bs_ready, chain_shift_en, ccff_head, busy, done, error});
        end
        pReset = 1'b0;
        @(negedge clk);
        abort_at = -1;
        run_load();
        checks++;
        if ({done, isol_n} !== 2'b11 || chain_m[19:0] !== ref_chain(3)) begin
            errors++; $display("FAIL midreset_reload: got done/isol %b chain %h expected 11 %h", {done, isol_n}, chain_m[19:0], ref_chain(3));
        end
    endtask

    task automatic test_start_while_busy();
        set_defaults();
        words[0] = 8'hA7; words[1] = 8'h0F; words[2] = 8'hE2;
        n_words = 3; poke_at = 14;
        run_load();
        checks++;
        if (!res_poked || res_shifts != TOTAL) begin errors++; $display("FAIL busy_start_shifts: got poked=%0d shifts %0d expected 1 %0d", res_poked, res_shifts, TOTAL); end
        checks++;
        if (chain_m[19:0] !== ref_chain(3) || done !== 1'b1) begin
            errors++; $display("FAIL busy_start_result: got chain %h done %b expected %h 1", chain_m[19:0], done, ref_chain(3));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_restart_from_done();
        test_stall();
        test_broken_chain();
        test_random();
        test_reset_mid_load();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
